uart_tx_fifo: RTL and testbench

Parametrised UART transmitter with an input FIFO, runtime baud divisor, configurable parity and stop bits. Next generation of the single-byte transmitter: accepts bursts of words without waiting on busy and sends them back-to-back. Sits between a bus-side register block and the serial TX pin.

---
 rtl/uart_tx_fifo.sv | 158 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a circular FIFO; frames go out back-to-back while words remain queued.
// Frame config (divisor, parity, stop bits) is latched per word at pop time.
module uart_tx_fifo #(
    parameter int DATA_W  = 8,
    parameter int FIFO_AW = 4,
    parameter int DIV_W   = 24
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_wr,
    input  logic [DATA_W-1:0] i_data,
    input  logic [DIV_W-1:0]  i_baud_div,
    input  logic              i_parity_en,
    input  logic              i_parity_odd,
    input  logic              i_two_stop,
    output logic              o_uart_tx,
    output logic              o_busy,
    output logic              o_full,
    output logic              o_empty,
    output logic [FIFO_AW:0]  o_fill,
    output logic              o_overflow
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2
    } state_t;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [FIFO_AW:0]  wr_ptr_q, rd_ptr_q, fill;
    logic              full, empty, wr_acc, pop, frame_end;
    logic [DATA_W-1:0] head;
    logic [DIV_W-1:0]  div_clamp;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d, div_q, div_d;
    logic [IDX_W-1:0]  bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              par_q, par_d, par_en_q, par_en_d, two_q, two_d;
    logic              tx_q, tx_d, ovf_q;

    // Pointers carry one extra bit so full and empty stay distinguishable.
    assign fill      = wr_ptr_q - rd_ptr_q;
    assign full      = (fill == (FIFO_AW+1)'(DEPTH));
    assign empty     = (fill == '0);
    assign wr_acc    = i_wr && !full;
    assign head      = mem_q[rd_ptr_q[FIFO_AW-1:0]];
    assign div_clamp = (i_baud_div < DIV_W'(2)) ? DIV_W'(2) : i_baud_div;

    always_ff @(posedge i_clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q[FIFO_AW-1:0]] <= i_data;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        par_d     = par_q;
        par_en_d  = par_en_q;
        two_d     = two_q;
        pop       = 1'b0;
        frame_end = 1'b0;

        if (state_q != S_IDLE) begin
            cnt_d = (cnt_q == '0) ? div_q - DIV_W'(1) : cnt_q - DIV_W'(1);
        end

        case (state_q)
            S_IDLE: ;
            S_START: if (cnt_q == '0) state_d = S_DATA;
            S_DATA: begin
                if (cnt_q == '0) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == IDX_W'(DATA_W-1)) begin
                        bit_d   = '0;
                        state_d = par_en_q ? S_PARITY : S_STOP1;
                    end else begin
                        bit_d = bit_q + IDX_W'(1);
                    end
                end
            end
            S_PARITY: if (cnt_q == '0) state_d = S_STOP1;
            S_STOP1: begin
                if (cnt_q == '0) begin
                    if (two_q) state_d = S_STOP2;
                    else       frame_end = 1'b1;
                end
            end
            S_STOP2: if (cnt_q == '0) frame_end = 1'b1;
            default: state_d = S_IDLE;
        endcase

        // A queued word starts on the same edge the previous stop bit ends.
        if ((state_q == S_IDLE || frame_end) && !empty) begin
            pop      = 1'b1;
            state_d  = S_START;
            shift_d  = head;
            par_d    = (^head) ^ i_parity_odd;
            div_d    = div_clamp;
            cnt_d    = div_clamp - DIV_W'(1);
            bit_d    = '0;
            par_en_d = i_parity_en;
            two_d    = i_two_stop;
        end else if (frame_end) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end

        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = par_q;
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            div_q    <= DIV_W'(2);
            bit_q    <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            par_en_q <= 1'b0;
            two_q    <= 1'b0;
            tx_q     <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr_q <= wr_ptr_q + (FIFO_AW+1)'(1);
            if (pop)    rd_ptr_q <= rd_ptr_q + (FIFO_AW+1)'(1);
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            par_en_q <= par_en_d;
            two_q    <= two_d;
            tx_q     <= tx_d;
            ovf_q    <= i_wr && full;
        end
    end

    assign o_uart_tx  = tx_q;
    assign o_busy     = (state_q != S_IDLE) || !empty;
    assign o_full     = full;
    assign o_empty    = empty;
    assign o_fill     = fill;
    assign o_overflow = ovf_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: expected line waveforms are built frame by frame from word and config,
// then compared cycle by cycle with the captured serial line.
module tb_uart_tx_fifo;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr = 1'b0, wr5 = 1'b0;
    logic [7:0]  data = '0;
    logic [4:0]  data5 = '0;
    logic [23:0] baud = 24'd4;
    logic        pen = 1'b0, podd = 1'b0, two = 1'b0;
    logic        tx, busy, full, empty, ovf;
    logic [4:0]  fill;
    logic        tx5, busy5, full5, empty5, ovf5;
    logic [4:0]  fill5;

    int n_checks = 0;
    int n_fail   = 0;
    bit exp_wave[$];
    bit got_wave[$];

    always #5 clk = ~clk;

    uart_tx_fifo #(.DATA_W(8), .FIFO_AW(4), .DIV_W(24)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_wr(wr), .i_data(data), .i_baud_div(baud),
        .i_parity_en(pen), .i_parity_odd(podd), .i_two_stop(two),
        .o_uart_tx(tx), .o_busy(busy), .o_full(full), .o_empty(empty),
        .o_fill(fill), .o_overflow(ovf)
    );

    uart_tx_fifo #(.DATA_W(5), .FIFO_AW(4), .DIV_W(24)) dut5 (
        .i_clk(clk), .i_rst_n(rst_n), .i_wr(wr5), .i_data(data5), .i_baud_div(baud),
        .i_parity_en(pen), .i_parity_odd(podd), .i_two_stop(two),
        .o_uart_tx(tx5), .o_busy(busy5), .o_full(full5), .o_empty(empty5),
        .o_fill(fill5), .o_overflow(ovf5)
    );

    // Append one frame's line levels, one entry per clock.
    function automatic void add_frame(input int unsigned word, input int nbits, input int div,
                                      input bit p_en, input bit p_odd, input bit two_s);
        int d   = (div < 2) ? 2 : div;
        bit par = p_odd;
        bit b;
        for (int r = 0; r < d; r++) exp_wave.push_back(1'b0);
        for (int k = 0; k < nbits; k++) begin
            b   = 1'((word >> k) & 1);
            par = par ^ b;
            for (int r = 0; r < d; r++) exp_wave.push_back(b);
        end
        if (p_en) for (int r = 0; r < d; r++) exp_wave.push_back(par);
        for (int r = 0; r < d * (two_s ? 2 : 1); r++) exp_wave.push_back(1'b1);
    endfunction

    function automatic int first_diff();
        for (int i = 0; i < exp_wave.size(); i++) begin
            if (i >= got_wave.size()) return i;
            if (got_wave[i] !== exp_wave[i]) return i;
        end
        return -1;
    endfunction

    // Skips the write edge, then samples from the cycle after the pop edge onward.
    task automatic capture(input int n, input bit use5);
        got_wave.delete();
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            got_wave.push_back(use5 ? tx5 : tx);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (tx !== 1'b1)   begin n_fail++; $display("FAIL reset_tx: got %0b want 1", tx); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy); end
        n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %0b want 0", full); end
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %0b want 1", empty); end
        n_checks++; if (fill !== 5'd0) begin n_fail++; $display("FAIL reset_fill: got %0d want 0", fill); end
        n_checks++; if (ovf !== 1'b0)  begin n_fail++; $display("FAIL reset_ovf: got %0b want 0", ovf); end
        n_checks++; if ({tx5, busy5, full5, empty5, fill5, ovf5} !== {1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0}) begin
            n_fail++; $display("FAIL reset_w5: got tx=%0b busy=%0b fill=%0d", tx5, busy5, fill5);
        end
        rst_n = 1'b1;
        @(negedge clk);
        $display("reset: done");
    endtask

    task automatic test_8n1();
        int idx;
        baud = 24'd4; pen = 1'b0; two = 1'b0;
        exp_wave.delete();
        add_frame(32'hA5, 8, 4, 1'b0, 1'b0, 1'b0);
        fork
            begin
                wr = 1'b1; data = 8'hA5;
                @(negedge clk);
                wr = 1'b0;
                n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL 8n1_latency: line %0b one cycle after write, want 1", tx); end
                n_checks++; if (fill !== 5'd1) begin n_fail++; $display("FAIL 8n1_fill: got %0d want 1", fill); end
                @(negedge clk);
                n_checks++; if (fill !== 5'd0 || busy !== 1'b1) begin
                    n_fail++; $display("FAIL 8n1_pop: fill=%0d busy=%0b want 0/1", fill, busy);
                end
            end
            capture(exp_wave.size(), 1'b0);
        join
        idx = first_diff();
        n_checks++; if (idx != -1) begin
            n_fail++; $display("FAIL 8n1_wave: cycle %0d line=%0b want %0b", idx, got_wave[idx], exp_wave[idx]);
        end
        @(negedge clk);
        n_checks++; if (busy !== 1'b0 || tx !== 1'b1) begin
            n_fail++; $display("FAIL 8n1_end: busy=%0b tx=%0b want 0/1", busy, tx);
        end
        $display("8n1: word 0xa5 div 4, %0d cycles compared", exp_wave.size());
    endtask

    task automatic test_parity();
        int idx;
        for (int odd = 0; odd < 2; odd++) begin
            baud = 24'd3; pen = 1'b1; podd = 1'(odd); two = 1'b1;
            exp_wave.delete();
            add_frame(32'h07, 8, 3, 1'b1, 1'(odd), 1'b1);
            fork
                begin
                    wr = 1'b1; data = 8'h07;
                    @(negedge clk);
                    wr = 1'b0;
                end
                capture(exp_wave.size(), 1'b0);
            join
            idx = first_diff();
            n_checks++; if (idx != -1) begin
                n_fail++; $display("FAIL parity_wave odd=%0d: cycle %0d line=%0b want %0b", odd, idx, got_wave[idx], exp_wave[idx]);
            end
            n_checks++; if (got_wave[28] !== ((odd == 0) ? 1'b1 : 1'b0)) begin
                n_fail++; $display("FAIL parity_bit odd=%0d: got %0b", odd, got_wave[28]);
            end
            @(negedge clk);
            n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL parity_end: busy=%0b want 0", busy); end
            $display("parity: word 0x07 odd=%0d two stop, %0d cycles compared", odd, exp_wave.size());
        end
        pen = 1'b0; podd = 1'b0; two = 1'b0;
    endtask

    task automatic test_fifo_full();
        int idx;
        baud = 24'd2;
        exp_wave.delete();
        for (int i = 0; i < 17; i++) add_frame(32'(i), 8, 2, 1'b0, 1'b0, 1'b0);
        fork
            begin
                for (int i = 0; i < 17; i++) begin
                    wr = 1'b1; data = 8'(i);
                    @(negedge clk);
                end
                n_checks++; if (full !== 1'b1 || fill !== 5'd16) begin
                    n_fail++; $display("FAIL full_flag: full=%0b fill=%0d want 1/16", full, fill);
                end
                data = 8'h11;
                @(negedge clk);
                wr = 1'b0;
                n_checks++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL full_ovf: got %0b want 1", ovf); end
                n_checks++; if (fill !== 5'd16) begin n_fail++; $display("FAIL full_drop: fill=%0d want 16", fill); end
                @(negedge clk);
                n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL full_ovf_pulse: got %0b want 0", ovf); end
            end
            capture(exp_wave.size(), 1'b0);
        join
        idx = first_diff();
        n_checks++; if (idx != -1) begin
            n_fail++; $display("FAIL full_wave: cycle %0d line=%0b want %0b", idx, got_wave[idx], exp_wave[idx]);
        end
        @(negedge clk);
        n_checks++; if (busy !== 1'b0 || empty !== 1'b1) begin
            n_fail++; $display("FAIL full_end: busy=%0b empty=%0b want 0/1", busy, empty);
        end
        $display("fifo_full: 17 words back-to-back, 18th dropped, %0d cycles compared", exp_wave.size());
    endtask

    task automatic test_div_change();
        int idx;
        logic [7:0] w1, w2;
        w1 = 8'($urandom); w2 = 8'($urandom);
        baud = 24'd0;
        exp_wave.delete();
        add_frame(32'(w1), 8, 0, 1'b0, 1'b0, 1'b0);
        add_frame(32'(w2), 8, 5, 1'b0, 1'b0, 1'b0);
        fork
            begin
                wr = 1'b1; data = w1;
                @(negedge clk);
                data = w2;
                @(negedge clk);
                wr = 1'b0;
                repeat (3) @(negedge clk);
                baud = 24'd5;
            end
            capture(exp_wave.size(), 1'b0);
        join
        idx = first_diff();
        n_checks++; if (idx != -1) begin
            n_fail++; $display("FAIL div_wave: cycle %0d line=%0b want %0b", idx, got_wave[idx], exp_wave[idx]);
        end
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL div_end: busy=%0b want 0", busy); end
        $display("div_change: words 0x%02h(div0) 0x%02h(div5), %0d cycles compared", w1, w2, exp_wave.size());
    endtask

    task automatic test_random();
        int idx, n, div;
        bit p_en, p_odd, t_s;
        logic [7:0] words[4];
        for (int burst = 0; burst < 4; burst++) begin
            n = $urandom_range(1, 4); div = $urandom_range(0, 5);
            p_en = 1'($urandom); p_odd = 1'($urandom); t_s = 1'($urandom);
            baud = 24'(div); pen = p_en; podd = p_odd; two = t_s;
            exp_wave.delete();
            for (int i = 0; i < n; i++) begin
                words[i] = 8'($urandom);
                add_frame(32'(words[i]), 8, div, p_en, p_odd, t_s);
            end
            fork
                begin
                    for (int i = 0; i < n; i++) begin
                        wr = 1'b1; data = words[i];
                        @(negedge clk);
                    end
                    wr = 1'b0;
                end
                capture(exp_wave.size(), 1'b0);
            join
            idx = first_diff();
            n_checks++; if (idx != -1) begin
                n_fail++; $display("FAIL random_wave burst=%0d: cycle %0d line=%0b want %0b", burst, idx, got_wave[idx], exp_wave[idx]);
            end
            @(negedge clk);
            n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL random_end burst=%0d: busy=%0b", burst, busy); end
            $display("random burst %0d: %0d words div=%0d par=%0b odd=%0b two=%0b", burst, n, div, p_en, p_odd, t_s);
        end
        pen = 1'b0; podd = 1'b0; two = 1'b0;
    endtask

    task automatic test_data_w5();
        int idx;
        baud = 24'd3;
        exp_wave.delete();
        add_frame(32'h1F, 5, 3, 1'b0, 1'b0, 1'b0);
        fork
            begin
                wr5 = 1'b1; data5 = 5'h1F;
                @(negedge clk);
                wr5 = 1'b0;
            end
            capture(exp_wave.size(), 1'b1);
        join
        idx = first_diff();
        n_checks++; if (idx != -1) begin
            n_fail++; $display("FAIL w5_wave: cycle %0d line=%0b want %0b", idx, got_wave[idx], exp_wave[idx]);
        end
        @(negedge clk);
        n_checks++; if (busy5 !== 1'b0 || tx5 !== 1'b1) begin
            n_fail++; $display("FAIL w5_end: busy=%0b tx=%0b want 0/1", busy5, tx5);
        end
        $display("data_w5: word 0x1f div 3, %0d cycles compared", exp_wave.size());
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        baud = 24'd4;
        wr = 1'b1; data = 8'h00;
        @(negedge clk); data = 8'h33;
        @(negedge clk); data = 8'h44;
        @(negedge clk); wr = 1'b0;
        repeat (9) @(negedge clk);
        n_checks++; if (tx !== 1'b0 || fill !== 5'd2) begin
            n_fail++; $display("FAIL rstmid_pre: tx=%0b fill=%0d want 0/2", tx, fill);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL rstmid_tx: got %0b want 1", tx); end
        n_checks++; if (fill !== 5'd0 || empty !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_fifo: fill=%0d empty=%0b busy=%0b want 0/1/0", fill, empty, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL rstmid_residual: %0d active cycles want 0", bad); end
        $display("reset_mid: reset during data bit, line idle afterwards");
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_fifo_full();
        test_div_change();
        test_random();
        test_data_w5();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
